// File: rtl/matmul_mem_pkg.sv
// Shared types and default widths for the matmul sequencer memory port.
// The request record is what the FIFO stores and what the SRAM pins are driven from.
package matmul_mem_pkg;

   localparam int MEM_AW         = 16;
   localparam int MEM_DW         = 32;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef struct packed {
      logic              we;
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] wdata;
   } mem_req_t;

   localparam mem_req_t MEM_REQ_RST = '{we: 1'b0, addr: {MEM_AW{1'b0}}, wdata: {MEM_DW{1'b0}}};

endpackage

// File: rtl/matmul_mem_port_if.sv
// Sequencer-side request bus: one-cycle requests with no ready, plus the read-return pulse.
interface matmul_mem_port_if;
   import matmul_mem_pkg::*;

   logic              mem_req;
   logic              mem_write;
   logic [MEM_AW-1:0] mem_addr;
   logic [MEM_DW-1:0] mem_wdata;
   logic              mem_rdata_vld;
   logic [MEM_DW-1:0] mem_rdata;

   modport master (
      output mem_req, mem_write, mem_addr, mem_wdata,
      input  mem_rdata_vld, mem_rdata
   );

   modport slave (
      input  mem_req, mem_write, mem_addr, mem_wdata,
      output mem_rdata_vld, mem_rdata
   );

endinterface

// File: rtl/mem_req_fifo.sv
// Request FIFO whose head entry lives in its own register so the SRAM pins come straight
// from flops; the ring keeps every entry and the head register mirrors ring[rd_ptr].
module mem_req_fifo
   import matmul_mem_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  mem_req_t               din,
   input  logic                   pop,
   output mem_req_t               head,
   output logic                   head_vld,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   mem_req_t        mem_r [DEPTH];
   mem_req_t        head_r;
   mem_req_t        head_nxt_s;
   logic            vld_r;
   logic            vld_nxt_s;
   logic [PW:0]     wr_ptr_r;
   logic [PW:0]     rd_ptr_r;
   logic [PW:0]     count_r;
   logic [PW-1:0]   rd_nxt_s;
   logic            empty_s;
   logic            full_s;
   logic            push_ok_s;
   logic            pop_ok_s;

   // Status from the pointers; the wrap bit separates full from empty.
   always_comb begin
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                  (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
      pop_ok_s  = pop & ~empty_s;
      push_ok_s = push & (~full_s | pop_ok_s);
      rd_nxt_s  = rd_ptr_r[PW-1:0] + PW'(1);
   end

   // Next head: the entry behind the old head, or the incoming one when it becomes the head.
   always_comb begin
      head_nxt_s = head_r;
      vld_nxt_s  = vld_r;
      if (pop_ok_s) begin
         if (count_r == (PW+1)'(1)) begin
            if (push_ok_s) begin
               head_nxt_s = din;
               vld_nxt_s  = 1'b1;
            end else begin
               vld_nxt_s  = 1'b0;
            end
         end else begin
            head_nxt_s = mem_r[rd_nxt_s];
            vld_nxt_s  = 1'b1;
         end
      end else if (push_ok_s && empty_s) begin
         head_nxt_s = din;
         vld_nxt_s  = 1'b1;
      end else begin
         head_nxt_s = head_r;
         vld_nxt_s  = vld_r;
      end
   end

   // Pointers, occupancy and the head register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {(PW+1){1'b0}};
         rd_ptr_r <= {(PW+1){1'b0}};
         count_r  <= {(PW+1){1'b0}};
         head_r   <= MEM_REQ_RST;
         vld_r    <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
         head_r <= head_nxt_s;
         vld_r  <= vld_nxt_s;
      end
   end

   // Ring storage; its contents are don't-care until written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[PW-1:0]] <= din;
      end
   end

   assign head     = head_r;
   assign head_vld = vld_r;
   assign full     = full_s;
   assign count    = count_r;

endmodule

// File: rtl/matmul_mem_port.sv
// Buffers sequencer requests (which cannot be back-pressured) and replays them to a granted
// single-port SRAM, returning read data two cycles after acceptance.
module matmul_mem_port
   import matmul_mem_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   matmul_mem_port_if.slave            bus,
   output logic                        sram_ce,
   output logic                        sram_we,
   output logic [MEM_AW-1:0]           sram_addr,
   output logic [MEM_DW-1:0]           sram_wdata,
   input  logic                        sram_gnt,
   input  logic [MEM_DW-1:0]           sram_rdata,
   output logic [$clog2(FIFO_DEPTH):0] req_count,
   output logic                        ovf,
   output logic                        idle
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   mem_req_t          din_s;
   mem_req_t          head_s;
   logic              head_vld_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              rd_acc_s;
   logic [CW-1:0]     count_s;
   logic [CW-1:0]     cnt_nxt_s;
   logic              ovf_r;
   logic              rd_p1_r;
   logic              rdata_vld_r;
   logic [MEM_DW-1:0] rdata_r;
   logic              idle_r;

   // A full FIFO still takes a request when its head leaves in the same cycle.
   always_comb begin
      din_s    = '{we: bus.mem_write, addr: bus.mem_addr, wdata: bus.mem_wdata};
      pop_s    = head_vld_s & sram_gnt;
      push_s   = bus.mem_req & (~full_s | pop_s);
      rd_acc_s = pop_s & ~head_s.we;
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = count_s + CW'(1);
         2'b01:   cnt_nxt_s = count_s - CW'(1);
         default: cnt_nxt_s = count_s;
      endcase
   end

   mem_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_s),
      .din      (din_s),
      .pop      (pop_s),
      .head     (head_s),
      .head_vld (head_vld_s),
      .full     (full_s),
      .count    (count_s)
   );

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (bus.mem_req & ~push_s) begin
         ovf_r <= 1'b1;
      end
   end

   // Read return: flag the accepted read, capture SRAM data next cycle, pulse valid after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_p1_r     <= 1'b0;
         rdata_vld_r <= 1'b0;
         rdata_r     <= {MEM_DW{1'b0}};
      end else begin
         rd_p1_r     <= rd_acc_s;
         rdata_vld_r <= rd_p1_r;
         if (rd_p1_r) begin
            rdata_r <= sram_rdata;
         end
      end
   end

   // Idle once nothing is queued, nothing awaits SRAM data and no valid pulse is due.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_r <= 1'b1;
      end else begin
         idle_r <= (cnt_nxt_s == {CW{1'b0}}) & ~rd_acc_s & ~rd_p1_r;
      end
   end

   assign sram_ce           = head_vld_s;
   assign sram_we           = head_s.we;
   assign sram_addr         = head_s.addr;
   assign sram_wdata        = head_s.wdata;
   assign req_count         = count_s;
   assign ovf               = ovf_r;
   assign idle              = idle_r;
   assign bus.mem_rdata_vld = rdata_vld_r;
   assign bus.mem_rdata     = rdata_r;

endmodule

// File: tb/tb_matmul_mem_port.sv
// Directed and random stimulus for matmul_mem_port checked every cycle against a
// queue-based reference model of the request FIFO and read return.
module tb_matmul_mem_port;
   import matmul_mem_pkg::*;

   localparam int DEPTH = DEF_FIFO_DEPTH;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sram_ce;
   logic              sram_we;
   logic [MEM_AW-1:0] sram_addr;
   logic [MEM_DW-1:0] sram_wdata;
   logic              sram_gnt;
   logic [MEM_DW-1:0] sram_rdata;
   logic [2:0]        req_count;
   logic              ovf;
   logic              idle;

   matmul_mem_port_if bus ();

   matmul_mem_port dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .sram_ce    (sram_ce),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_gnt   (sram_gnt),
      .sram_rdata (sram_rdata),
      .req_count  (req_count),
      .ovf        (ovf),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   mem_req_t          q[$];
   bit                ovf_m;
   bit                rp1_m;
   bit                vld_m;
   logic [MEM_DW-1:0] data_m;

   bit                fixed_rd;
   logic [MEM_DW-1:0] fixed_val;
   int                acc_cnt;
   int                vld_cnt;
   int                max_cnt;
   int                last_vld_cyc;
   int                req_cyc;
   bit                idle_seen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      ovf_m  = 1'b0;
      rp1_m  = 1'b0;
      vld_m  = 1'b0;
      data_m = '0;
   endtask

   // One clock: compare outputs at the falling edge, advance the model, move to the next cycle.
   task automatic step();
      bit pop;
      bit push;
      @(negedge clk);
      cyc++;
      chk("sram_ce", sram_ce, q.size() != 0);
      if (q.size() != 0) begin
         chk("sram_we", sram_we, q[0].we);
         chk("sram_addr", sram_addr, q[0].addr);
         chk("sram_wdata", sram_wdata, q[0].wdata);
      end
      chk("req_count", req_count, q.size());
      chk("ovf", ovf, ovf_m);
      chk("rdata_vld", bus.mem_rdata_vld, vld_m);
      if (vld_m) chk("rdata", bus.mem_rdata, data_m);
      chk("idle", idle, (q.size() == 0) && !rp1_m && !vld_m);

      if (sram_ce && sram_gnt) acc_cnt++;
      if (bus.mem_rdata_vld) begin
         vld_cnt++;
         last_vld_cyc = cyc;
      end
      if (int'(req_count) > max_cnt) max_cnt = int'(req_count);
      idle_seen = idle;

      if (rst_n) begin
         pop   = (q.size() != 0) && sram_gnt;
         push  = bus.mem_req && ((q.size() < DEPTH) || pop);
         vld_m = rp1_m;
         if (rp1_m) data_m = sram_rdata;
         rp1_m = pop && !q[0].we;
         if (pop) void'(q.pop_front());
         if (push) q.push_back('{we: bus.mem_write, addr: bus.mem_addr, wdata: bus.mem_wdata});
         else if (bus.mem_req) ovf_m = 1'b1;
      end else begin
         model_reset();
      end

      @(posedge clk);
      #1;
      sram_rdata = fixed_rd ? fixed_val : $urandom;
   endtask

   task automatic issue(input bit w, input logic [MEM_AW-1:0] a, input logic [MEM_DW-1:0] d);
      bus.mem_req   = 1'b1;
      bus.mem_write = w;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      step();
      bus.mem_req   = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input int bound);
      bit done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         step();
         if (idle_seen) done = 1'b1;
      end
      chk("drain_timeout", done, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step();
      chk("rst_sram_we", sram_we, 1'b0);
      chk("rst_sram_addr", sram_addr, 16'h0000);
      chk("rst_sram_wdata", sram_wdata, 32'h0000_0000);
      chk("rst_rdata", bus.mem_rdata, 32'h0000_0000);
      chk("rst_idle", idle, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.mem_req   = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      sram_gnt      = 1'b0;
      sram_rdata    = '0;
      fixed_rd      = 1'b0;
      fixed_val     = '0;
      acc_cnt       = 0;
      vld_cnt       = 0;
      max_cnt       = 0;
      last_vld_cyc  = 0;
      rst_n         = 1'b0;
      model_reset();
      #1;
      step();
      do_reset();

      // Single write
      sram_gnt = 1'b1;
      acc_cnt  = 0;
      vld_cnt  = 0;
      issue(1'b1, 16'h0010, 32'hFFFF_FFEE);
      idle_steps(3);
      chk("wr_accesses", acc_cnt, 1);
      chk("wr_no_vld", vld_cnt, 0);
      chk("wr_idle", idle, 1'b1);

      // Single read with a known SRAM return value
      fixed_rd   = 1'b1;
      fixed_val  = 32'h1234_5678;
      sram_rdata = fixed_val;
      vld_cnt    = 0;
      req_cyc    = cyc + 1;
      issue(1'b0, 16'h0020, 32'h0000_0000);
      idle_steps(4);
      chk("rd_pulses", vld_cnt, 1);
      chk("rd_latency", last_vld_cyc - req_cyc, 3);
      chk("rd_data", bus.mem_rdata, 32'h1234_5678);
      fixed_rd = 1'b0;

      // Eight back-to-back alternating writes and reads
      max_cnt = 0;
      vld_cnt = 0;
      for (int i = 0; i < 8; i++) issue(((i % 2) == 0), MEM_AW'($urandom), $urandom);
      idle_steps(4);
      chk("b2b_ovf", ovf, 1'b0);
      chk("b2b_pulses", vld_cnt, 4);
      chk("b2b_maxcnt", max_cnt <= 1, 1'b1);

      // No grant: four queue up, the fifth is dropped
      sram_gnt = 1'b0;
      for (int i = 0; i < 5; i++) issue($urandom_range(0, 1), MEM_AW'($urandom), $urandom);
      chk("stall_count", req_count, 3'd4);
      chk("stall_ovf", ovf, 1'b1);
      sram_gnt = 1'b1;
      acc_cnt  = 0;
      drain(20);
      chk("stall_accesses", acc_cnt, 4);
      chk("stall_ovf_sticky", ovf, 1'b1);

      // Full FIFO with grant: a new request rides along with the pop
      do_reset();
      sram_gnt = 1'b0;
      for (int i = 0; i < 4; i++) issue($urandom_range(0, 1), MEM_AW'($urandom), $urandom);
      sram_gnt = 1'b1;
      issue(1'b0, 16'hBEEF, 32'h0);
      chk("full_pp_count", req_count, 3'd4);
      chk("full_pp_ovf", ovf, 1'b0);
      drain(20);

      // Random traffic with random grants
      for (int i = 0; i < 300; i++) begin
         sram_gnt      = ($urandom_range(0, 3) != 0);
         bus.mem_req   = $urandom_range(0, 1);
         bus.mem_write = $urandom_range(0, 1);
         bus.mem_addr  = MEM_AW'($urandom);
         bus.mem_wdata = $urandom;
         step();
      end
      bus.mem_req = 1'b0;
      sram_gnt    = 1'b1;
      drain(20);

      // Reset one cycle after a read is accepted
      issue(1'b0, 16'h0040, 32'h0);
      step();
      rst_n = 1'b0;
      model_reset();
      vld_cnt = 0;
      step();
      step();
      rst_n = 1'b1;
      idle_steps(5);
      chk("rst_mid_no_vld", vld_cnt, 0);
      chk("rst_mid_count", req_count, 3'd0);
      chk("rst_mid_ovf", ovf, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
